// File: rtl/rx_frame_parser.sv
// rtl/rx_frame_parser.sv - header/payload/trailer frame parser writing payload into accelerator buffers
module rx_frame_parser #(
    parameter int          DATA_W = 256,
    parameter int          ADDR_W = 12,
    parameter logic [15:0] MAGIC  = 16'hA55A
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_vld,
    output logic              ready,
    input  logic              sink_ready,
    output logic              buf_wr_en,
    output logic [1:0]        buf_sel,
    output logic [ADDR_W-1:0] buf_wr_addr,
    output logic [DATA_W-1:0] buf_wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err,
    output logic [1:0]        err_code
);

    typedef enum logic [1:0] {HDR, PAY, TRL} state_t;

    state_t              state_q, state_d;
    logic [15:0]         k_q, k_d;
    logic [15:0]         n_q, n_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [31:0]         csum_q, csum_d;
    logic [1:0]          sel_q, sel_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [1:0]          code_q, code_d;

    logic                accept;
    logic [31:0]         lane_x;
    logic [16:0]         hdr_end;
    logic [16:0]         hdr_limit;

    function automatic logic [31:0] lane_xor(input logic [DATA_W-1:0] w);
        logic [31:0] x;
        x = '0;
        for (int i = 0; i < DATA_W / 32; i++) begin
            x = x ^ w[i*32 +: 32];
        end
        return x;
    endfunction

    always_comb begin
        ready = 1'b1;
        if (state_q == PAY) begin
            ready = sink_ready;
        end
    end

    assign accept    = din_vld && ready;
    assign lane_x    = lane_xor(din);
    // Range check is done one bit wider so base + N cannot wrap past the buffer end.
    assign hdr_end   = 17'(din[ADDR_W+175:176]) + 17'(din[207:192]);
    assign hdr_limit = 17'(1) << ADDR_W;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        n_d     = n_q;
        base_d  = base_q;
        csum_d  = csum_q;
        sel_d   = sel_q;
        wr_en_d = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        case (state_q)
            HDR: begin
                if (accept) begin
                    if (din[255:240] != MAGIC) begin
                        err_d  = 1'b1;
                        code_d = 2'd1;
                    end else if (din[239:232] > 8'd2 || din[207:192] == 16'd0 ||
                                 hdr_end > hdr_limit) begin
                        err_d  = 1'b1;
                        code_d = 2'd2;
                    end else begin
                        sel_d   = din[233:232];
                        base_d  = din[ADDR_W+175:176];
                        n_d     = din[207:192];
                        k_d     = '0;
                        csum_d  = '0;
                        state_d = PAY;
                    end
                end
            end
            PAY: begin
                if (accept) begin
                    wr_en_d = 1'b1;
                    addr_d  = base_q + k_q[ADDR_W-1:0];
                    data_d  = din;
                    csum_d  = csum_q ^ lane_x;
                    k_d     = k_q + 16'd1;
                    if (k_q == n_q - 16'd1) begin
                        state_d = TRL;
                    end
                end
            end
            TRL: begin
                if (accept) begin
                    if (din[31:0] == csum_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                        code_d = 2'd3;
                    end
                    state_d = HDR;
                end
            end
            default: state_d = HDR;
        endcase
        busy_d = (state_d != HDR);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= HDR;
            k_q     <= '0;
            n_q     <= '0;
            base_q  <= '0;
            csum_q  <= '0;
            sel_q   <= '0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            n_q     <= n_d;
            base_q  <= base_d;
            csum_q  <= csum_d;
            sel_q   <= sel_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign buf_wr_en   = wr_en_q;
    assign buf_sel     = sel_q;
    assign buf_wr_addr = addr_q;
    assign buf_wr_data = data_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign frame_err   = err_q;
    assign err_code    = code_q;

endmodule

// File: tb/tb_rx_frame_parser.sv
// tb/tb_rx_frame_parser.sv - directed self-checking bench for rx_frame_parser
module tb_rx_frame_parser;

    logic         sys_clk = 1'b0;
    logic         sys_rst_n = 1'b0;
    logic [255:0] din = '0;
    logic         din_vld = 1'b0;
    logic         ready;
    logic         sink_ready = 1'b1;
    logic         buf_wr_en;
    logic [1:0]   buf_sel;
    logic [11:0]  buf_wr_addr;
    logic [255:0] buf_wr_data;
    logic         busy;
    logic         frame_done;
    logic         frame_err;
    logic [1:0]   err_code;

    int vec_cnt = 0;
    int miss_cnt = 0;

    logic [11:0]  wr_addr_log [0:15];
    logic [255:0] wr_data_log [0:15];
    logic [1:0]   wr_sel_log  [0:15];
    int           wr_n = 0;
    int           done_n = 0;
    int           err_n = 0;

    logic         sr_pat [0:7];
    int           sr_len = 0;
    int           sr_idx = 0;
    logic         chk_ready = 1'b0;

    rx_frame_parser #(.DATA_W(256), .ADDR_W(12), .MAGIC(16'hA55A)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .din        (din),
        .din_vld    (din_vld),
        .ready      (ready),
        .sink_ready (sink_ready),
        .buf_wr_en  (buf_wr_en),
        .buf_sel    (buf_sel),
        .buf_wr_addr(buf_wr_addr),
        .buf_wr_data(buf_wr_data),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .err_code   (err_code)
    );

    always #5 sys_clk = ~sys_clk;

    // Passive log of every write and status pulse, sampled mid-cycle.
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (buf_wr_en && wr_n < 16) begin
                wr_addr_log[wr_n] = buf_wr_addr;
                wr_data_log[wr_n] = buf_wr_data;
                wr_sel_log[wr_n]  = buf_sel;
                wr_n = wr_n + 1;
            end
            if (frame_done) done_n = done_n + 1;
            if (frame_err)  err_n = err_n + 1;
        end
    end

    function automatic logic [255:0] hdr(input logic [15:0] magic, input logic [7:0] typ,
                                         input logic [15:0] n, input logic [11:0] base);
        logic [255:0] h;
        h = '0;
        h[255:240] = magic;
        h[239:232] = typ;
        h[207:192] = n;
        h[187:176] = base;
        return h;
    endfunction

    function automatic logic [255:0] pay(input logic [31:0] seed);
        logic [255:0] w;
        for (int l = 0; l < 8; l++) begin
            w[l*32 +: 32] = (32'h0101_0101 * (l + 1)) ^ (seed << l);
        end
        return w;
    endfunction

    function automatic logic [31:0] lanes(input logic [255:0] w);
        logic [31:0] x;
        x = '0;
        for (int l = 0; l < 8; l++) x = x ^ w[l*32 +: 32];
        return x;
    endfunction

    // Called at a negedge; returns at the negedge following the accept edge with din_vld still high.
    task automatic send(input logic [255:0] w);
        logic acc;
        acc = 1'b0;
        din = w;
        din_vld = 1'b1;
        for (int c = 0; c < 50 && !acc; c++) begin
            if (sr_idx < sr_len) begin
                sink_ready = sr_pat[sr_idx];
                sr_idx = sr_idx + 1;
            end else begin
                sink_ready = 1'b1;
            end
            #1;
            if (chk_ready) begin
                vec_cnt++;
                if (ready !== sink_ready) begin
                    miss_cnt++;
                    $display("FAIL ready_follow: ready=%b sink_ready=%b", ready, sink_ready);
                end
            end
            acc = ready;
            @(negedge sys_clk);
        end
        if (!acc) begin
            vec_cnt++;
            miss_cnt++;
            $display("FAIL send_timeout: accepted=0 required=1");
        end
    endtask

    task automatic idle(input int cycles);
        din_vld = 1'b0;
        sink_ready = 1'b1;
        repeat (cycles) @(negedge sys_clk);
    endtask

    task automatic clear_log();
        wr_n = 0;
        done_n = 0;
        err_n = 0;
    endtask

    task automatic check_writes(input string name, input int n, input logic [11:0] base,
                                input logic [1:0] sel, input logic [31:0] seed0);
        vec_cnt++;
        if (wr_n !== n) begin
            miss_cnt++;
            $display("FAIL %s_count: got %0d writes, want %0d", name, wr_n, n);
        end
        for (int i = 0; i < n && i < wr_n; i++) begin
            vec_cnt++;
            if (wr_addr_log[i] !== base + 12'(i) || wr_data_log[i] !== pay(seed0 + i) ||
                wr_sel_log[i] !== sel) begin
                miss_cnt++;
                $display("FAIL %s_wr%0d: addr=%h sel=%0d want addr=%h sel=%0d", name, i,
                         wr_addr_log[i], wr_sel_log[i], base + 12'(i), sel);
            end
        end
    endtask

    task automatic test_reset();
        vec_cnt++;
        if ({buf_wr_en, buf_wr_addr, buf_sel, busy, frame_done, frame_err, err_code} !== '0 ||
            buf_wr_data !== '0 || ready !== 1'b1) begin
            miss_cnt++;
            $display("FAIL reset_state: wr_en=%b addr=%h sel=%0d busy=%b done=%b err=%b code=%0d ready=%b",
                     buf_wr_en, buf_wr_addr, buf_sel, busy, frame_done, frame_err, err_code, ready);
        end
    endtask

    task automatic test_good_frame();
        logic [31:0] cs;
        clear_log();
        cs = lanes(pay(32'h100)) ^ lanes(pay(32'h101)) ^ lanes(pay(32'h102));
        send(hdr(16'hA55A, 8'd1, 16'd3, 12'h010));
        vec_cnt++;
        if (busy !== 1'b1) begin
            miss_cnt++;
            $display("FAIL good_busy_rise: busy=%b want 1", busy);
        end
        for (int i = 0; i < 3; i++) begin
            send(pay(32'h100 + i));
            vec_cnt++;
            if (buf_wr_en !== 1'b1 || buf_wr_addr !== 12'h010 + 12'(i) || buf_sel !== 2'd1) begin
                miss_cnt++;
                $display("FAIL good_wr_latency%0d: wr_en=%b addr=%h sel=%0d", i, buf_wr_en, buf_wr_addr, buf_sel);
            end
        end
        send({224'h0, cs});
        vec_cnt++;
        if (frame_done !== 1'b1 || busy !== 1'b0 || frame_err !== 1'b0) begin
            miss_cnt++;
            $display("FAIL good_done: done=%b busy=%b err=%b want 1 0 0", frame_done, busy, frame_err);
        end
        idle(2);
        check_writes("good", 3, 12'h010, 2'd1, 32'h100);
        vec_cnt++;
        if (done_n !== 1 || err_n !== 0) begin
            miss_cnt++;
            $display("FAIL good_pulses: done=%0d err=%0d want 1 0", done_n, err_n);
        end
    endtask

    task automatic test_bad_magic();
        clear_log();
        send(hdr(16'h1234, 8'd1, 16'd1, 12'h000));
        vec_cnt++;
        if (frame_err !== 1'b1 || err_code !== 2'd1 || busy !== 1'b0) begin
            miss_cnt++;
            $display("FAIL magic_err: err=%b code=%0d busy=%b want 1 1 0", frame_err, err_code, busy);
        end
        send(hdr(16'hA55A, 8'd0, 16'd1, 12'h200));
        send(pay(32'h300));
        send({224'h0, lanes(pay(32'h300))});
        vec_cnt++;
        if (frame_done !== 1'b1) begin
            miss_cnt++;
            $display("FAIL magic_recover_done: done=%b want 1", frame_done);
        end
        idle(2);
        check_writes("magic", 1, 12'h200, 2'd0, 32'h300);
    endtask

    task automatic test_bad_header();
        logic [255:0] cases [0:2];
        cases[0] = hdr(16'hA55A, 8'd1, 16'd0, 12'h010);
        cases[1] = hdr(16'hA55A, 8'd3, 16'd2, 12'h010);
        cases[2] = hdr(16'hA55A, 8'd2, 16'd3, 12'hFFE);
        for (int i = 0; i < 3; i++) begin
            clear_log();
            send(cases[i]);
            vec_cnt++;
            if (frame_err !== 1'b1 || err_code !== 2'd2 || busy !== 1'b0 || ready !== 1'b1) begin
                miss_cnt++;
                $display("FAIL bad_hdr%0d: err=%b code=%0d busy=%b ready=%b want 1 2 0 1",
                         i, frame_err, err_code, busy, ready);
            end
            idle(2);
            vec_cnt++;
            if (wr_n !== 0) begin
                miss_cnt++;
                $display("FAIL bad_hdr%0d_writes: got %0d want 0", i, wr_n);
            end
        end
    endtask

    task automatic test_checksum_bad();
        logic [31:0] cs;
        clear_log();
        cs = lanes(pay(32'h400)) ^ lanes(pay(32'h401));
        send(hdr(16'hA55A, 8'd2, 16'd2, 12'h0A0));
        send(pay(32'h400));
        send(pay(32'h401));
        send({224'h0, cs ^ 32'h1});
        vec_cnt++;
        if (frame_err !== 1'b1 || err_code !== 2'd3 || frame_done !== 1'b0) begin
            miss_cnt++;
            $display("FAIL csum_err: err=%b code=%0d done=%b want 1 3 0", frame_err, err_code, frame_done);
        end
        idle(3);
        vec_cnt++;
        if (err_code !== 2'd3 || done_n !== 0) begin
            miss_cnt++;
            $display("FAIL csum_hold: code=%0d done_pulses=%0d want 3 0", err_code, done_n);
        end
        check_writes("csum", 2, 12'h0A0, 2'd2, 32'h400);
    endtask

    task automatic test_backpressure();
        logic [31:0] cs;
        clear_log();
        cs = lanes(pay(32'h500)) ^ lanes(pay(32'h501)) ^ lanes(pay(32'h502));
        send(hdr(16'hA55A, 8'd1, 16'd3, 12'h7F0));
        sr_pat[0] = 1'b1; sr_pat[1] = 1'b0; sr_pat[2] = 1'b0; sr_pat[3] = 1'b1;
        sr_len = 4;
        sr_idx = 0;
        chk_ready = 1'b1;
        send(pay(32'h500));
        send(pay(32'h501));
        send(pay(32'h502));
        chk_ready = 1'b0;
        sr_len = 0;
        send({224'h0, cs});
        vec_cnt++;
        if (frame_done !== 1'b1) begin
            miss_cnt++;
            $display("FAIL bp_done: done=%b want 1", frame_done);
        end
        idle(2);
        check_writes("bp", 3, 12'h7F0, 2'd1, 32'h500);
    endtask

    task automatic test_reset_mid_frame();
        clear_log();
        send(hdr(16'hA55A, 8'd0, 16'd5, 12'h020));
        send(pay(32'h600));
        send(pay(32'h601));
        sys_rst_n = 1'b0;
        din_vld = 1'b0;
        #1;
        test_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        vec_cnt++;
        if (err_n !== 0 || frame_err !== 1'b0 || busy !== 1'b0) begin
            miss_cnt++;
            $display("FAIL rst_no_err: err_pulses=%0d err=%b busy=%b want 0 0 0", err_n, frame_err, busy);
        end
        clear_log();
        send(hdr(16'hA55A, 8'd2, 16'd2, 12'h030));
        send(pay(32'h700));
        send(pay(32'h701));
        send({224'h0, lanes(pay(32'h700)) ^ lanes(pay(32'h701))});
        vec_cnt++;
        if (frame_done !== 1'b1) begin
            miss_cnt++;
            $display("FAIL rst_next_done: done=%b want 1", frame_done);
        end
        idle(2);
        check_writes("rst_next", 2, 12'h030, 2'd2, 32'h700);
    endtask

    initial begin
        repeat (3) @(negedge sys_clk);
        test_reset();
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        test_reset();
        test_good_frame();
        test_bad_magic();
        test_bad_header();
        test_checksum_bad();
        test_backpressure();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/rx_frame_parser.md
# rx_frame_parser

Frame parser that sits directly downstream of the UART receive/FIFO stage. It consumes the 256-bit words that stage emits on `din`/`din_vld` and drives its `ready` input. Each frame is one header word, N payload words and one trailer word. The block validates the header, writes the payload into the selected accelerator buffer (weight, feature or bias) at consecutive addresses, checks a 32-bit XOR checksum, and reports completion or error.

## Interface
Parameters:
- `DATA_W`, 256: word width; fixed by the upstream stage.
- `ADDR_W`, 12: buffer address width, 1..16.
- `MAGIC`, 16'hA55A: header sync pattern.

Ports:
- `sys_clk`  in  1  system clock; single clock domain.
- `sys_rst_n`  in  1  reset, asynchronous, active-low.
- `din`  in  256  word from the upstream FIFO stage.
- `din_vld`  in  1  `din` valid.
- `ready`  out  1  block accepts `din` this cycle; drives the upstream `ready`.
- `sink_ready`  in  1  target buffer can take a write this cycle.
- `buf_wr_en`  out  1  buffer write strobe.
- `buf_sel`  out  2  target buffer: 0 weight, 1 feature, 2 bias.
- `buf_wr_addr`  out  ADDR_W  write address.
- `buf_wr_data`  out  256  write data.
- `busy`  out  1  a frame is in progress (state is not HDR).
- `frame_done`  out  1  one-cycle pulse: frame received with a good checksum.
- `frame_err`  out  1  one-cycle pulse: frame rejected or checksum bad.
- `err_code`  out  2  valid with `frame_err`: 1 bad magic, 2 bad header, 3 checksum mismatch.

## Operation
- Transfer rule: a word is accepted on a cycle with `din_vld && ready`.
- `ready` is combinational:
  - HDR: 1
  - PAY: `sink_ready`
  - TRL: 1
- Header word fields:
  - `din[255:240]` magic
  - `din[239:232]` type (must be 0, 1 or 2)
  - `din[207:192]` payload count N (16 bits)
  - `din[ADDR_W+175:176]` base address
- State HDR, on header accept:
  - magic ≠ MAGIC → `frame_err` with code 1; stay in HDR. This resyncs one word at a time.
  - type > 2, or N = 0, or base + N > 2^ADDR_W (computed 17 bits wide) → code 2; stay in HDR.
  - otherwise: latch type, base and N; clear the word counter k and the checksum register; go to PAY.
- State PAY, per payload word accept:
  - buffer write at address base + k with `din` as data.
  - checksum ^= XOR of the eight 32-bit lanes of `din`.
  - k increments; accepting word k = N−1 moves the state to TRL.
- State TRL, on accept:
  - compare `din[31:0]` with the checksum.
  - equal → `frame_done`; different → `frame_err` with code 3.
  - go to HDR either way. Payload already written is not rolled back.
- `buf_sel` holds the latched type from header accept until the next good header.
- Reset, including mid-frame: state returns to HDR; k, checksum, base, N and `buf_sel` clear to 0. The partial frame is abandoned. No checksum or length check is made on the partial frame, and no error pulse is issued.

## Timing
- Reset values: `buf_wr_en` 0, `buf_wr_addr` 0, `buf_wr_data` 0, `buf_sel` 0, `busy` 0, `frame_done` 0, `frame_err` 0, `err_code` 0. `ready` = 1 after reset because the state is HDR.
- All outputs except `ready` are registered.
- Write latency: payload accepted in cycle t → `buf_wr_en` = 1 in cycle t+1, with that word's address and data. With back-to-back accepts, `buf_wr_en` stays high continuously.
- `sink_ready` is sampled in the accept cycle. The buffer must take the write issued in the next cycle unconditionally.
- Header accepted in cycle t → `busy` = 1 from t+1. Trailer accepted in cycle t → `busy` = 0 in t+1.
- `frame_done` / `frame_err` pulse in cycle t+1 after the deciding accept.
- `err_code` holds its value until the next `frame_err`.
- Last payload accepted at t → state is TRL at t+1, so a trailer can be accepted at t+1.
- Minimum frame length is N+2 cycles, with no idle cycle required between frames.
- `din_vld` low in any state: no state change and no writes.
- No timeout: the block waits indefinitely for the next word.

## Test plan
- Good frame: type 1, base 0x010, N = 3, payload words P0..P2, correct trailer → writes to addresses 0x010, 0x011, 0x012 with `buf_sel` = 1; `frame_done` pulses 1 cycle after the trailer; `busy` falls in that cycle.
- Bad magic: header `din[255:240]` = 16'h1234 → `frame_err` with code 1, no writes; an immediately following good frame completes normally.
- Bad header, one frame per case, each → code 2, no writes, state stays HDR:
  - N = 0
  - type = 3
  - base 0xFFE with N = 3 (0xFFE + 3 > 2^12)
- Checksum bad: trailer `din[31:0]` = correct ^ 1 → all N writes still occur; `frame_err` with code 3; no `frame_done`.
- Backpressure: `sink_ready` toggles 1,0,0,1 during the payload → `ready` follows it; no write is lost or duplicated; addresses remain contiguous.
- Reset mid-payload: assert `sys_rst_n` low after 2 of 5 payload words → all outputs go to their reset values; no error pulse is issued; the next good frame completes with its own base address.
